// File: rtl/serial_adder_pkg.sv
// +-----------------------------------------------------------------+
// | serial_adder_pkg: shared FSM state type and counter-width helper|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit-index counter width; never narrower than one bit.
  function automatic int CNT_W(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// +-----------------------------------------------------------------+
// | full_adder: one-bit sum and carry cell                          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// +-----------------------------------------------------------------+
// | serial_adder: LSB-first bit-serial two's-complement adder with  |
// | start/busy/done handshake and registered results. Rev 1.0       |
// +-----------------------------------------------------------------+
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int            CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic             cim_q, cim_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_full_adder (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      cim_q     <= 1'b0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      cim_q     <= cim_d;
      bit_cnt_q <= bit_cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cim_d     = cim_q;
    bit_cnt_d = bit_cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d    = a;
          b_sr_d    = b;
          sum_sr_d  = '0;
          carry_d   = 1'b0;
          cim_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sr_d           = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1]  = fa_sum;
        a_sr_d             = a_sr_q >> 1;
        b_sr_d             = b_sr_q >> 1;
        carry_d            = fa_cout;
        if (bit_cnt_q == PRE_MSB) begin
          cim_d = fa_cout;
        end
        // The counter parks on the MSB index instead of wrapping.
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = sum_sr_d;
          cout_d  = fa_cout;
          ovf_d   = cim_q ^ fa_cout;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// +-----------------------------------------------------------------+
// | tb_serial_adder: self-checking bench for serial_adder (8 and 4) |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ovf8;
  logic       start4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ovf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result as {overflow, cout, sum}.
  function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    int u;
    int s;
    logic [9:0] r;
    u = int'(x) + int'(y);
    s = int'($signed(x)) + int'($signed(y));
    r[7:0] = u[7:0];
    r[8]   = (u > 255);
    r[9]   = (s > 127) || (s < -128);
    return r;
  endfunction

  // One 8-bit operation observed over 12 cycles after the accepting edge.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] esum,
                     input logic ec, input logic eo, input bit meddle, input string tag);
    logic [11:0] bv;
    logic [11:0] dv;
    logic [7:0]  rs;
    logic        rc;
    logic        ro;
    bit          held;
    bv = '0; dv = '0; rs = '0; rc = 1'b0; ro = 1'b0; held = 1'b1;
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start8 = 1'b0; a8 = ~ia; b8 = 8'h3C;
      end
      if (meddle && k == 2) begin
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
      end
      if (meddle && k == 3) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      bv[k] = busy8;
      dv[k] = done8;
      if (k == 8) begin
        rs = sum8; rc = cout8; ro = ovf8;
      end
      if (k > 8 && {sum8, cout8, ovf8} !== {rs, rc, ro}) held = 1'b0;
    end
    check({tag, " busy"}, 32'(bv), 32'h1FF);
    check({tag, " done"}, 32'(dv), 32'h100);
    check({tag, " sum"}, 32'(rs), 32'(esum));
    check({tag, " cout"}, 32'(rc), 32'(ec));
    check({tag, " ovf"}, 32'(ro), 32'(eo));
    check({tag, " hold"}, 32'(held), 32'd1);
  endtask

  initial begin
    vec_t        tbl [4];
    logic [9:0]  r;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [29:0] dv4;
    logic [29:0] ev4;
    bit          saw_done;

    reset = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("reset outs8", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
    check("reset outs4", 32'({busy4, done4, cout4, ovf4, sum4}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    tbl[0] = '{8'd23,  8'd19,  8'd42,  1'b0, 1'b0};
    tbl[1] = '{8'hFF,  8'h01,  8'h00,  1'b1, 1'b0};
    tbl[2] = '{8'h7F,  8'h01,  8'h80,  1'b0, 1'b1};
    tbl[3] = '{8'h80,  8'h80,  8'h00,  1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].o, 1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle hold %0d", i), 32'({busy8, done8, sum8, cout8, ovf8}),
            32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b1}));
    end

    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      r = ref_add(x, y);
      op8(x, y, r[7:0], r[8], r[9], 1'b0, $sformatf("rnd%0d", i));
    end

    op8(8'd5, 8'd6, 8'd11, 1'b0, 1'b0, 1'b1, "mid_start");

    // Reset asserted between E4 and E5 of an in-flight operation.
    saw_done = 1'b0;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) saw_done = 1'b1;
    end
    #1 reset = 1'b1;
    #1;
    check("async reset outs", 32'({busy8, done8, sum8, cout8, ovf8}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("no done after abort", 32'(saw_done), 32'd0);
    op8(8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, "post_reset");

    // WIDTH=4, start held high: one result every WIDTH+2 cycles.
    dv4 = '0;
    ev4 = '0;
    for (int k = 4; k < 30; k += 6) ev4[k] = 1'b1;
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h9; start4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      dv4[k] = done4;
      if (done4) begin
        check($sformatf("w4 result k%0d", k), 32'({sum4, cout4, ovf4}),
              32'({4'h0, 1'b1, 1'b0}));
      end
    end
    start4 = 1'b0;
    check("w4 done cadence", 32'(dv4), 32'(ev4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
